// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit CPU datapath: a step counter (RST, T0-T7, HALT)
// plus a combinational decode of that step and the opcode into every datapath strobe.
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stop,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        HIin,
    output logic        LOin,
    output logic        PCin,
    output logic        MDRin,
    output logic        Zin,
    output logic        Yin,
    output logic        MARin,
    output logic        IRin,
    output logic        CONin,
    output logic        OUTPORTin,
    output logic        HIout,
    output logic        LOout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        PCout,
    output logic        MDRout,
    output logic        INPORTout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic [4:0]  AluOp,
    output logic        Run
);

    localparam logic [3:0] RST  = 4'd0;
    localparam logic [3:0] T0   = 4'd1;
    localparam logic [3:0] T1   = 4'd2;
    localparam logic [3:0] T2   = 4'd3;
    localparam logic [3:0] T3   = 4'd4;
    localparam logic [3:0] T4   = 4'd5;
    localparam logic [3:0] T5   = 4'd6;
    localparam logic [3:0] T6   = 4'd7;
    localparam logic [3:0] T7   = 4'd8;
    localparam logic [3:0] HALT = 4'd9;

    localparam logic [4:0] opLd   = 5'b00000;
    localparam logic [4:0] opLdi  = 5'b00001;
    localparam logic [4:0] opSt   = 5'b00010;
    localparam logic [4:0] opAdd  = 5'b00011;
    localparam logic [4:0] opRol  = 5'b01011;
    localparam logic [4:0] opAddi = 5'b01100;
    localparam logic [4:0] opOri  = 5'b01110;
    localparam logic [4:0] opMul  = 5'b01111;
    localparam logic [4:0] opDiv  = 5'b10000;
    localparam logic [4:0] opNeg  = 5'b10001;
    localparam logic [4:0] opNot  = 5'b10010;
    localparam logic [4:0] opBr   = 5'b10011;
    localparam logic [4:0] opJr   = 5'b10100;
    localparam logic [4:0] opJal  = 5'b10101;
    localparam logic [4:0] opIn   = 5'b10110;
    localparam logic [4:0] opOut  = 5'b10111;
    localparam logic [4:0] opMfhi = 5'b11000;
    localparam logic [4:0] opMflo = 5'b11001;
    localparam logic [4:0] opNop  = 5'b11010;
    localparam logic [4:0] opHalt = 5'b11011;

    logic [3:0] state;
    logic [3:0] nextState;
    logic [4:0] opcode;
    logic       lastStep;
    logic       unusedIrFields;

    logic isLd, isLdi, isSt, isRegAlu, isImmAlu, isMulDiv, isNegNot;
    logic isBr, isJr, isJal, isIn, isOut, isMfhi, isMflo, isNop, isHalt;

    assign opcode         = IR[31:27];
    assign unusedIrFields = ^IR[26:0];

    assign isLd     = (opcode == opLd);
    assign isLdi    = (opcode == opLdi);
    assign isSt     = (opcode == opSt);
    assign isRegAlu = (opcode >= opAdd) && (opcode <= opRol);
    assign isImmAlu = (opcode >= opAddi) && (opcode <= opOri);
    assign isMulDiv = (opcode == opMul) || (opcode == opDiv);
    assign isNegNot = (opcode == opNeg) || (opcode == opNot);
    assign isBr     = (opcode == opBr);
    assign isJr     = (opcode == opJr);
    assign isJal    = (opcode == opJal);
    assign isIn     = (opcode == opIn);
    assign isOut    = (opcode == opOut);
    assign isMfhi   = (opcode == opMfhi);
    assign isMflo   = (opcode == opMflo);
    assign isHalt   = (opcode == opHalt);
    // Reserved opcodes 11100-11111 retire after fetch exactly like nop.
    assign isNop    = (opcode == opNop) || (opcode > opHalt);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= RST;
        end else begin
            state <= nextState;
        end
    end

    // Final step of each instruction class; any path reaching T7 always ends there.
    always_comb begin
        lastStep = 1'b0;
        case (state)
            T2:      lastStep = isNop;
            T3:      lastStep = isJr | isIn | isOut | isMfhi | isMflo;
            T4:      lastStep = isJal | isNegNot;
            T5:      lastStep = isRegAlu | isImmAlu | isLdi;
            T6:      lastStep = isMulDiv | isBr;
            T7:      lastStep = 1'b1;
            default: lastStep = 1'b0;
        endcase
    end

    always_comb begin
        nextState = state;
        case (state)
            RST:  nextState = T0;
            T0:   nextState = T1;
            T1:   nextState = T2;
            HALT: nextState = HALT;
            T2, T3, T4, T5, T6, T7: begin
                if (state == T2 && isHalt) begin
                    nextState = HALT;
                end else if (lastStep) begin
                    nextState = Stop ? HALT : T0;
                end else begin
                    nextState = state + 4'd1;
                end
            end
            default: nextState = RST;
        endcase
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        HIin      = 1'b0;
        LOin      = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        Zin       = 1'b0;
        Yin       = 1'b0;
        MARin     = 1'b0;
        IRin      = 1'b0;
        CONin     = 1'b0;
        OUTPORTin = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        ZHIout    = 1'b0;
        ZLOout    = 1'b0;
        PCout     = 1'b0;
        MDRout    = 1'b0;
        INPORTout = 1'b0;
        Cout      = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        BAout     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        IncPC     = 1'b0;
        AluOp     = 5'b00000;
        Run       = (state >= T0) && (state <= T7);

        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (isRegAlu || isImmAlu) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (isNegNot) begin
                    Grb   = 1'b1;
                    Rout  = 1'b1;
                    Zin   = 1'b1;
                    AluOp = opcode;
                end else if (isMulDiv) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (isLd || isLdi || isSt) begin
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end else if (isBr) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end else if (isJr) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else if (isJal) begin
                    PCout = 1'b1;
                    Grb   = 1'b1;
                    Rin   = 1'b1;
                end else if (isIn) begin
                    INPORTout = 1'b1;
                    Gra       = 1'b1;
                    Rin       = 1'b1;
                end else if (isOut) begin
                    Gra       = 1'b1;
                    Rout      = 1'b1;
                    OUTPORTin = 1'b1;
                end else if (isMfhi) begin
                    HIout = 1'b1;
                    Gra   = 1'b1;
                    Rin   = 1'b1;
                end else if (isMflo) begin
                    LOout = 1'b1;
                    Gra   = 1'b1;
                    Rin   = 1'b1;
                end
            end
            T4: begin
                if (isRegAlu) begin
                    Grc   = 1'b1;
                    Rout  = 1'b1;
                    Zin   = 1'b1;
                    AluOp = opcode;
                end else if (isImmAlu) begin
                    Cout  = 1'b1;
                    Zin   = 1'b1;
                    AluOp = opcode;
                end else if (isNegNot) begin
                    ZLOout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (isMulDiv) begin
                    Grb   = 1'b1;
                    Rout  = 1'b1;
                    Zin   = 1'b1;
                    AluOp = opcode;
                end else if (isLd || isLdi || isSt) begin
                    Cout  = 1'b1;
                    Zin   = 1'b1;
                    AluOp = opAdd;
                end else if (isBr) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end else if (isJal) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end
            end
            T5: begin
                if (isRegAlu || isImmAlu || isLdi) begin
                    ZLOout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (isMulDiv) begin
                    ZLOout = 1'b1;
                    LOin   = 1'b1;
                end else if (isLd || isSt) begin
                    ZLOout = 1'b1;
                    MARin  = 1'b1;
                end else if (isBr) begin
                    Cout  = 1'b1;
                    Zin   = 1'b1;
                    AluOp = opAdd;
                end
            end
            T6: begin
                if (isMulDiv) begin
                    ZHIout = 1'b1;
                    HIin   = 1'b1;
                end else if (isLd) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (isSt) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end else if (isBr && CON) begin
                    ZLOout = 1'b1;
                    PCin   = 1'b1;
                end
            end
            T7: begin
                if (isLd) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (isSt) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each step pushes the expected strobe word for every
// cycle onto a scoreboard, which is popped and compared on the falling clock edge.
module tb_control_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Stop;
    logic [31:0] IR;
    logic        CON;
    logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, Run;
    logic [4:0]  AluOp;

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR), .CON(CON),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
        .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
        .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
        .MDRout(MDRout), .INPORTout(INPORTout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Read(Read), .Write(Write), .IncPC(IncPC), .AluOp(AluOp), .Run(Run)
    );

    localparam logic [27:0] kHIin      = 28'd1 << 0;
    localparam logic [27:0] kLOin      = 28'd1 << 1;
    localparam logic [27:0] kPCin      = 28'd1 << 2;
    localparam logic [27:0] kMDRin     = 28'd1 << 3;
    localparam logic [27:0] kZin       = 28'd1 << 4;
    localparam logic [27:0] kYin       = 28'd1 << 5;
    localparam logic [27:0] kMARin     = 28'd1 << 6;
    localparam logic [27:0] kIRin      = 28'd1 << 7;
    localparam logic [27:0] kCONin     = 28'd1 << 8;
    localparam logic [27:0] kOUTPORTin = 28'd1 << 9;
    localparam logic [27:0] kHIout     = 28'd1 << 10;
    localparam logic [27:0] kLOout     = 28'd1 << 11;
    localparam logic [27:0] kZHIout    = 28'd1 << 12;
    localparam logic [27:0] kZLOout    = 28'd1 << 13;
    localparam logic [27:0] kPCout     = 28'd1 << 14;
    localparam logic [27:0] kMDRout    = 28'd1 << 15;
    localparam logic [27:0] kINPORTout = 28'd1 << 16;
    localparam logic [27:0] kCout      = 28'd1 << 17;
    localparam logic [27:0] kGra       = 28'd1 << 18;
    localparam logic [27:0] kGrb       = 28'd1 << 19;
    localparam logic [27:0] kGrc       = 28'd1 << 20;
    localparam logic [27:0] kRin       = 28'd1 << 21;
    localparam logic [27:0] kRout      = 28'd1 << 22;
    localparam logic [27:0] kBAout     = 28'd1 << 23;
    localparam logic [27:0] kRead      = 28'd1 << 24;
    localparam logic [27:0] kWrite     = 28'd1 << 25;
    localparam logic [27:0] kIncPC     = 28'd1 << 26;
    localparam logic [27:0] kRun       = 28'd1 << 27;

    logic [32:0] expQ[$];
    string       tagQ[$];
    int          checks   = 0;
    int          failures = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [32:0] obsNow();
        return {Run, IncPC, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra, Cout, INPORTout,
                MDRout, PCout, ZLOout, ZHIout, LOout, HIout, OUTPORTin, CONin, IRin, MARin,
                Yin, Zin, MDRin, PCin, LOin, HIin, AluOp};
    endfunction

    task automatic check(input string tag, input logic [32:0] observed, input logic [32:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step(input string tag, input logic [27:0] flags, input logic [4:0] alu);
        expQ.push_back({flags, alu});
        tagQ.push_back(tag);
    endtask

    task automatic pushFetch(input string name);
        step({name, ".T0"}, kRun | kPCout | kMARin | kIncPC | kZin, 5'd0);
        step({name, ".T1"}, kRun | kZLOout | kPCin | kRead | kMDRin, 5'd0);
        step({name, ".T2"}, kRun | kMDRout | kIRin, 5'd0);
    endtask

    task automatic drainN(input int n);
        logic [32:0] e;
        string       t;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL scoreboard observed=empty required=entry");
                return;
            end
            e = expQ.pop_front();
            t = tagQ.pop_front();
            check(t, obsNow(), e);
        end
    endtask

    task automatic drainAll();
        drainN(expQ.size());
    endtask

    // Presents a new instruction just after the edge that enters T0.
    task automatic startInstr(input logic [4:0] op, input logic con);
        @(posedge Clock);
        #1;
        IR  = {op, 27'($urandom)};
        CON = con;
    endtask

    initial begin
        Reset = 1'b0;
        Stop  = 1'b0;
        CON   = 1'b0;
        IR    = 32'd0;

        step("reset.0", 28'd0, 5'd0);
        step("reset.1", 28'd0, 5'd0);
        drainAll();

        @(posedge Clock);
        #1;
        Reset = 1'b1;
        IR    = {5'b00011, 27'($urandom)};
        step("add.rst", 28'd0, 5'd0);
        pushFetch("add");
        step("add.T3", kRun | kGrb | kRout | kYin, 5'd0);
        step("add.T4", kRun | kGrc | kRout | kZin, 5'b00011);
        step("add.T5", kRun | kZLOout | kGra | kRin, 5'd0);
        drainAll();

        startInstr(5'b00010, 1'b0);
        pushFetch("st");
        step("st.T3", kRun | kGrb | kBAout | kYin, 5'd0);
        step("st.T4", kRun | kCout | kZin, 5'b00011);
        step("st.T5", kRun | kZLOout | kMARin, 5'd0);
        step("st.T6", kRun | kGra | kRout | kMDRin, 5'd0);
        step("st.T7", kRun | kWrite, 5'd0);
        drainAll();

        startInstr(5'b10011, 1'b0);
        pushFetch("br0");
        step("br0.T3", kRun | kGra | kRout | kCONin, 5'd0);
        step("br0.T4", kRun | kPCout | kYin, 5'd0);
        step("br0.T5", kRun | kCout | kZin, 5'b00011);
        step("br0.T6", kRun, 5'd0);
        drainAll();

        startInstr(5'b10011, 1'b1);
        pushFetch("br1");
        step("br1.T3", kRun | kGra | kRout | kCONin, 5'd0);
        step("br1.T4", kRun | kPCout | kYin, 5'd0);
        step("br1.T5", kRun | kCout | kZin, 5'b00011);
        step("br1.T6", kRun | kZLOout | kPCin, 5'd0);
        drainAll();

        startInstr(5'b01100, 1'b0);
        pushFetch("addi");
        step("addi.T3", kRun | kGrb | kRout | kYin, 5'd0);
        step("addi.T4", kRun | kCout | kZin, 5'b01100);
        step("addi.T5", kRun | kZLOout | kGra | kRin, 5'd0);
        drainAll();

        startInstr(5'b10001, 1'b0);
        pushFetch("neg");
        step("neg.T3", kRun | kGrb | kRout | kZin, 5'b10001);
        step("neg.T4", kRun | kZLOout | kGra | kRin, 5'd0);
        drainAll();

        // Stop pulsed across a non-final edge must not end jal early or halt it.
        startInstr(5'b10101, 1'b0);
        pushFetch("jal");
        step("jal.T3", kRun | kPCout | kGrb | kRin, 5'd0);
        step("jal.T4", kRun | kGra | kRout | kPCin, 5'd0);
        drainN(3);
        Stop = 1'b1;
        drainN(1);
        Stop = 1'b0;
        drainAll();

        startInstr(5'b11010, 1'b0);
        pushFetch("nop");
        drainAll();

        startInstr(5'b11101, 1'b0);
        pushFetch("undef");
        drainAll();

        startInstr(5'b11000, 1'b0);
        pushFetch("mfhi");
        step("mfhi.T3", kRun | kHIout | kGra | kRin, 5'd0);
        drainAll();

        startInstr(5'b11001, 1'b0);
        pushFetch("mflo");
        step("mflo.T3", kRun | kLOout | kGra | kRin, 5'd0);
        drainAll();

        startInstr(5'b10110, 1'b0);
        pushFetch("in");
        step("in.T3", kRun | kINPORTout | kGra | kRin, 5'd0);
        drainAll();

        startInstr(5'b10111, 1'b0);
        pushFetch("out");
        step("out.T3", kRun | kGra | kRout | kOUTPORTin, 5'd0);
        drainAll();

        startInstr(5'b00000, 1'b0);
        Stop = 1'b1;
        pushFetch("ld");
        step("ld.T3", kRun | kGrb | kBAout | kYin, 5'd0);
        step("ld.T4", kRun | kCout | kZin, 5'b00011);
        step("ld.T5", kRun | kZLOout | kMARin, 5'd0);
        step("ld.T6", kRun | kRead | kMDRin, 5'd0);
        step("ld.T7", kRun | kMDRout | kGra | kRin, 5'd0);
        for (int i = 0; i < 3; i++) step($sformatf("ld.halt%0d", i), 28'd0, 5'd0);
        drainAll();
        Stop = 1'b0;

        Reset = 1'b0;
        #1;
        check("halt.reset", obsNow(), 33'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        IR    = {5'b01111, 27'($urandom)};
        step("mulA.rst", 28'd0, 5'd0);
        pushFetch("mulA");
        step("mulA.T3", kRun | kGra | kRout | kYin, 5'd0);
        step("mulA.T4", kRun | kGrb | kRout | kZin, 5'b01111);
        drainAll();
        #2;
        Reset = 1'b0;
        #1;
        check("mulA.abort", obsNow(), 33'd0);
        step("mulA.held0", 28'd0, 5'd0);
        step("mulA.held1", 28'd0, 5'd0);
        drainAll();

        @(posedge Clock);
        #1;
        Reset = 1'b1;
        step("mul.rst", 28'd0, 5'd0);
        pushFetch("mul");
        step("mul.T3", kRun | kGra | kRout | kYin, 5'd0);
        step("mul.T4", kRun | kGrb | kRout | kZin, 5'b01111);
        step("mul.T5", kRun | kZLOout | kLOin, 5'd0);
        step("mul.T6", kRun | kZHIout | kHIin, 5'd0);
        drainAll();

        startInstr(5'b10000, 1'b0);
        pushFetch("div");
        step("div.T3", kRun | kGra | kRout | kYin, 5'd0);
        step("div.T4", kRun | kGrb | kRout | kZin, 5'b10000);
        step("div.T5", kRun | kZLOout | kLOin, 5'd0);
        step("div.T6", kRun | kZHIout | kHIin, 5'd0);
        drainAll();

        startInstr(5'b11011, 1'b0);
        pushFetch("halt");
        for (int i = 0; i < 20; i++) step($sformatf("halt.hold%0d", i), 28'd0, 5'd0);
        drainAll();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit CPU datapath. It sequences the fetch and execute steps from the opcode in the instruction register and the branch condition flag. It drives every register enable, bus-source select, register-file decode, memory strobe and ALU operation select. It sits beside the datapath and replaces hand-driven control stimulus.

## Interface
Parameters:
- none.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stop  in  1  halt request, sampled at instruction end.
- IR  in  32  instruction register contents; opcode = IR[31:27].
- CON  in  1  branch condition flag from the CON flip-flop.
- HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin  out  1 each  register load enables.
- HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout  out  1 each  bus source selects.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file field select and strobes.
- Read, Write  out  1 each  memory strobes.
- IncPC  out  1  ALU computes PC+1.
- AluOp  out  5  ALU operation select.
- Run  out  1  high while the processor is executing.

## Operation
- Opcodes:
  - ld=00000, ldi=00001, st=00010
  - add..rol=00011–01011
  - addi/andi/ori=01100–01110
  - mul=01111, div=10000, neg=10001, not=10010
  - br=10011, jr=10100, jal=10101
  - in=10110, out=10111
  - mfhi=11000, mflo=11001
  - nop=11010, halt=11011
  - 11100–11111 execute as nop.
- States: RST, T0–T7, HALT. Steps not listed drive every output to 0.
- AluOp rules:
  - Equals the opcode on the ALU-class Zin steps.
  - Equals 00011 (add) on the address and branch-target Zin steps.
  - Is 0 otherwise.
- Fetch (all instructions):
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLOout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Register ALU (00011–01011): T3 Grb Rout Yin; T4 Grc Rout Zin; T5 ZLOout Gra Rin.
- Immediate ALU: T3 Grb Rout Yin; T4 Cout Zin; T5 ZLOout Gra Rin.
- neg/not: T3 Grb Rout Zin; T4 ZLOout Gra Rin.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin; T5 ZLOout LOin; T6 ZHIout HIin.
- ld: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLOout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
- ldi: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLOout Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
- br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 ZLOout PCin only if CON=1, else idle.
- jr: T3 Gra Rout PCin.
- jal: T3 PCout Grb Rin (link register is the rb field); T4 Gra Rout PCin.
- in: T3 INPORTout Gra Rin. out: T3 Gra Rout OUTPORTin.
- mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
- nop and undefined opcodes: end at T2.
- End of instruction:
  - Next state is T0, or HALT if Stop=1 on that edge.
  - A halt opcode goes T2→HALT unconditionally.
- HALT: all outputs 0, Run=0. Exit only by Reset.

## Timing
- Outputs are a combinational decode of the state register and IR, valid for the whole cycle. The datapath captures them on the next rising edge.
- Reset=0 forces RST immediately: all outputs 0, Run=0. Reset mid-instruction abandons it; no partial write occurs beyond edges already taken.
- After Reset rises: one cycle in RST (Run=0), then T0 with Run=1 from that cycle onward.
- The IR is loaded at the end of T2. T3 decoding uses the new opcode.
- Cycle counts, including fetch: nop 3, jr/in/out/mfhi/mflo 4, jal/neg/not 5, ALU/ldi 6, mul/div/br 7, ld/st 8.
- Stop is ignored except on final-step edges. Stop asserted then deasserted before the instruction ends has no effect.

## Test plan
- Reset low for 2 cycles, then high → all outputs 0 during reset. RST for 1 cycle, then T0 with PCout=MARin=IncPC=Zin=1 and Run=1.
- IR=add (00011) → T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with AluOp=00011, T5 ZLOout/Gra/Rin, then T0; 6 cycles total.
- IR=st (00010) → Write=1 only in T7, with AluOp=00011 in T4 and Read=0 in T6; next instruction fetch starts at cycle 9.
- IR=br with CON=0, then with CON=1 → PCin=0 vs PCin=1 in T6; both return to T0 after 7 cycles.
- IR=halt → Run falls after T2 and the FSM stays in HALT for 20 cycles. Stop=1 during an ld enters HALT after T7 instead.
- Reset pulsed low during T4 of mul → all outputs 0 asynchronously; HIin/LOin are never asserted. The fetch restarts after RST.
